// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding and default widths.
package fetch_pkg;

    localparam int unsigned PC_W_DEF    = 30;
    localparam int unsigned INSTR_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Handshake bundles of the fetch stage: instruction-memory request/response and decode output.
interface fetch_imem_if
    import fetch_pkg::*;
#(
    parameter int unsigned PC_W    = PC_W_DEF,
    parameter int unsigned INSTR_W = INSTR_W_DEF
);
    logic               req_valid;
    logic               req_ready;
    logic [PC_W+1:0]    req_addr;
    logic               rsp_valid;
    logic [INSTR_W-1:0] rsp_instr;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_instr
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_instr
    );
endinterface

interface fetch_out_if
    import fetch_pkg::*;
#(
    parameter int unsigned PC_W    = PC_W_DEF,
    parameter int unsigned INSTR_W = INSTR_W_DEF
);
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;

    modport master (
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready
    );
endinterface

// File: rtl/next_pc_sel.sv
// Redirect resolution: conditional branch, direct jump and register jump, priority jr > j > branch.
module next_pc_sel
    import fetch_pkg::*;
#(
    parameter int unsigned PC_W = PC_W_DEF
) (
    input  logic            br_eq,
    input  logic            br_ne,
    input  logic            zero,
    input  logic [PC_W-1:0] br_pc,
    input  logic [15:0]     br_imm,
    input  logic            j,
    input  logic [23:0]     j_imm,
    input  logic            jr,
    input  logic [PC_W-1:0] jr_target,
    output logic            redirect,
    output logic [PC_W-1:0] target
);
    logic            take;
    logic [PC_W-1:0] br_target;
    logic [PC_W-1:0] j_target;

    always_comb begin
        take      = (br_eq & zero) | (br_ne & ~zero);
        // Signed size cast sign-extends the word offset before the modulo-2^PC_W add.
        br_target = br_pc + PC_W'(1) + PC_W'($signed(br_imm));
        j_target  = {br_pc[PC_W-1:24], j_imm};
        redirect  = jr | j | take;
        if (jr) begin
            target = jr_target;
        end else if (j) begin
            target = j_target;
        end else begin
            target = br_target;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding imem request, in-order fetch queue, redirect flush.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned          PC_W     = PC_W_DEF,
    parameter int unsigned          INSTR_W  = INSTR_W_DEF,
    parameter int unsigned          DEPTH    = 2,
    parameter logic [PC_W-1:0]      RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    fetch_imem_if.master    imem,
    fetch_out_if.master     dec,
    input  logic            br_eq,
    input  logic            br_ne,
    input  logic            zero,
    input  logic [PC_W-1:0] br_pc,
    input  logic [15:0]     br_imm,
    input  logic            j,
    input  logic [23:0]     j_imm,
    input  logic            jr,
    input  logic [PC_W-1:0] jr_target
);
    localparam int unsigned        PTR_W    = $clog2(DEPTH);
    localparam int unsigned        CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]    req_pc_q, req_pc_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [INSTR_W-1:0] instr_q [DEPTH];
    logic [INSTR_W-1:0] instr_d [DEPTH];
    logic [PC_W-1:0]    qpc_q   [DEPTH];
    logic [PC_W-1:0]    qpc_d   [DEPTH];

    logic            redirect;
    logic [PC_W-1:0] target;
    logic            req_valid;
    logic            out_valid;
    logic            req_fire;
    logic            push;
    logic            pop;

    next_pc_sel #(
        .PC_W (PC_W)
    ) u_next_pc_sel (
        .br_eq     (br_eq),
        .br_ne     (br_ne),
        .zero      (zero),
        .br_pc     (br_pc),
        .br_imm    (br_imm),
        .j         (j),
        .j_imm     (j_imm),
        .jr        (jr),
        .jr_target (jr_target),
        .redirect  (redirect),
        .target    (target)
    );

    // Gated by rst so no request is presented while reset is held.
    assign req_valid      = rst & (state_q == ST_IDLE) & (count_q < FULL_CNT) & ~redirect;
    assign out_valid      = (count_q != '0);
    assign imem.req_valid = req_valid;
    assign imem.req_addr  = {fetch_pc_q, 2'b00};
    assign dec.out_valid  = out_valid;
    assign dec.out_instr  = instr_q[head_q];
    assign dec.out_pc     = qpc_q[head_q];

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        instr_d    = instr_q;
        qpc_d      = qpc_q;

        req_fire = req_valid & imem.req_ready;
        push     = (state_q == ST_WAIT) & imem.rsp_valid & ~redirect;
        pop      = out_valid & dec.out_ready & ~redirect;

        case (state_q)
            ST_IDLE: begin
                if (req_fire) begin
                    state_d    = ST_WAIT;
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + PC_W'(1);
                end
            end
            ST_WAIT: begin
                // A response landing with the redirect is consumed here, so nothing is left to drop.
                if (imem.rsp_valid) begin
                    state_d = ST_IDLE;
                end else if (redirect) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (imem.rsp_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (push) begin
            instr_d[tail_q] = imem.rsp_instr;
            qpc_d[tail_q]   = req_pc_q;
            tail_d          = tail_q + PTR_W'(1);
        end
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (redirect) begin
            fetch_pc_d = target;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            instr_q    <= '{default: '0};
            qpc_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            instr_q    <= instr_d;
            qpc_q      <= qpc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency imem model returning the byte address as data.
module tb_fetch_unit;
    localparam int unsigned PC_W    = 30;
    localparam int unsigned INSTR_W = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            br_eq, br_ne, zero, j, jr;
    logic [PC_W-1:0] br_pc, jr_target;
    logic [15:0]     br_imm;
    logic [23:0]     j_imm;

    int checks = 0;
    int errors = 0;

    int unsigned mem_lat  = 1;
    bit          mem_busy = 1'b0;
    int unsigned mem_cnt  = 0;
    logic [31:0] mem_addr = '0;
    logic [31:0] acc_log [$];

    fetch_imem_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) imem ();
    fetch_out_if  #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dec ();

    fetch_unit #(
        .PC_W     (PC_W),
        .INSTR_W  (INSTR_W),
        .DEPTH    (2),
        .RESET_PC (30'd0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .imem      (imem),
        .dec       (dec),
        .br_eq     (br_eq),
        .br_ne     (br_ne),
        .zero      (zero),
        .br_pc     (br_pc),
        .br_imm    (br_imm),
        .j         (j),
        .j_imm     (j_imm),
        .jr        (jr),
        .jr_target (jr_target)
    );

    always #5 clk = ~clk;

    // Memory model: accept seen in cycle t answers in cycle t+mem_lat; unaware of DUT reset.
    always @(negedge clk) begin
        imem.rsp_valid = 1'b0;
        if (mem_busy) begin
            mem_cnt = mem_cnt - 1;
            if (mem_cnt == 0) begin
                imem.rsp_valid = 1'b1;
                imem.rsp_instr = mem_addr;
                mem_busy       = 1'b0;
            end
        end
        if (imem.req_valid === 1'b1 && imem.req_ready === 1'b1) begin
            mem_busy = 1'b1;
            mem_cnt  = mem_lat;
            mem_addr = imem.req_addr;
            acc_log.push_back(imem.req_addr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redirect();
        br_eq = 0; br_ne = 0; zero = 0; j = 0; jr = 0;
        br_pc = '0; br_imm = '0; j_imm = '0; jr_target = '0;
    endtask

    // Leaves the bench at the first cycle after reset release (DUT IDLE, empty).
    task automatic do_reset();
        rst = 1'b0;
        imem.req_ready = 1'b1;
        clear_redirect();
        repeat (6) tick();
        acc_log.delete();
        rst = 1'b1;
        #1;
    endtask

    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dec.out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        checks++; if (imem.req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", imem.req_valid); end
        checks++; if (imem.req_addr !== 32'h0) begin errors++; $display("FAIL reset_req_addr: got %h want 0", imem.req_addr); end
        checks++; if (dec.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", dec.out_valid); end
        checks++; if (dec.out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr: got %h want 0", dec.out_instr); end
        checks++; if (dec.out_pc !== 30'h0) begin errors++; $display("FAIL reset_out_pc: got %h want 0", dec.out_pc); end
    endtask

    task automatic test_stream();
        bit ok;
        mem_lat = 1;
        dec.out_ready = 1'b1;
        do_reset();
        checks++; if (imem.req_valid !== 1'b1) begin errors++; $display("FAIL stream_first_req: got %b want 1", imem.req_valid); end
        checks++; if (imem.req_addr !== 32'h0) begin errors++; $display("FAIL stream_first_addr: got %h want 0", imem.req_addr); end
        for (int i = 0; i < 3; i++) begin
            wait_out(ok);
            checks++; if (!ok) begin errors++; $display("FAIL stream_timeout_%0d: got no out_valid want out_valid", i); end
            checks++; if (dec.out_pc !== PC_W'(i)) begin errors++; $display("FAIL stream_pc_%0d: got %h want %h", i, dec.out_pc, i); end
            checks++; if (dec.out_instr !== 32'(4 * i)) begin errors++; $display("FAIL stream_instr_%0d: got %h want %h", i, dec.out_instr, 4 * i); end
        end
        checks++;
        if (acc_log.size() < 3) begin
            errors++; $display("FAIL stream_req_count: got %0d want >=3", acc_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (acc_log[i] !== 32'(4 * i)) begin errors++; $display("FAIL stream_req_addr_%0d: got %h want %h", i, acc_log[i], 4 * i); end
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        mem_lat = 1;
        dec.out_ready = 1'b0;
        do_reset();
        repeat (15) tick();
        checks++; if (acc_log.size() != 2) begin errors++; $display("FAIL bp_req_count: got %0d want 2", acc_log.size()); end
        checks++; if (imem.req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid_full: got %b want 0", imem.req_valid); end
        checks++; if (dec.out_valid !== 1'b1 || dec.out_pc !== 30'h0 || dec.out_instr !== 32'h0) begin
            errors++; $display("FAIL bp_head_hold: got v=%b pc=%h instr=%h want v=1 pc=0 instr=0", dec.out_valid, dec.out_pc, dec.out_instr); end
        dec.out_ready = 1'b1;
        tick();
        checks++; if (dec.out_valid !== 1'b1 || dec.out_pc !== 30'h1 || dec.out_instr !== 32'h4) begin
            errors++; $display("FAIL bp_second: got v=%b pc=%h instr=%h want v=1 pc=1 instr=4", dec.out_valid, dec.out_pc, dec.out_instr); end
        wait_out(ok);
        checks++; if (!ok || dec.out_pc !== 30'h2 || dec.out_instr !== 32'h8) begin
            errors++; $display("FAIL bp_resume: got ok=%b pc=%h instr=%h want ok=1 pc=2 instr=8", ok, dec.out_pc, dec.out_instr); end
        checks++; if (acc_log.size() < 3 || acc_log[acc_log.size() >= 3 ? 2 : 0] !== 32'h8) begin
            errors++; $display("FAIL bp_resume_addr: got size=%0d want third req at 8", acc_log.size()); end
    endtask

    task automatic test_branch();
        bit ok;
        mem_lat = 3;
        dec.out_ready = 1'b1;
        do_reset();
        tick();
        checks++; if (imem.req_valid !== 1'b0) begin errors++; $display("FAIL br_wait_state: got req_valid=%b want 0", imem.req_valid); end
        br_ne = 1'b1; zero = 1'b0; br_pc = 30'h10; br_imm = 16'hFFFE;
        tick();
        clear_redirect();
        #1;
        checks++; if (imem.req_valid !== 1'b0 || dec.out_valid !== 1'b0) begin
            errors++; $display("FAIL br_drop_c2: got req=%b out=%b want 0 0", imem.req_valid, dec.out_valid); end
        tick();
        checks++; if (imem.req_valid !== 1'b0 || dec.out_valid !== 1'b0) begin
            errors++; $display("FAIL br_drop_c3: got req=%b out=%b want 0 0", imem.req_valid, dec.out_valid); end
        tick();
        checks++; if (dec.out_valid !== 1'b0) begin errors++; $display("FAIL br_stale_pushed: got out_valid=%b want 0", dec.out_valid); end
        checks++; if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'h3C) begin
            errors++; $display("FAIL br_new_req: got v=%b addr=%h want v=1 addr=3c", imem.req_valid, imem.req_addr); end
        wait_out(ok);
        checks++; if (!ok || dec.out_pc !== 30'hF || dec.out_instr !== 32'h3C) begin
            errors++; $display("FAIL br_target_out: got ok=%b pc=%h instr=%h want ok=1 pc=f instr=3c", ok, dec.out_pc, dec.out_instr); end
    endtask

    task automatic test_flush();
        bit ok;
        mem_lat = 1;
        dec.out_ready = 1'b0;
        do_reset();
        repeat (10) tick();
        checks++; if (dec.out_valid !== 1'b1) begin errors++; $display("FAIL flush_prefill: got out_valid=%b want 1", dec.out_valid); end
        jr = 1'b1; jr_target = 30'h40;
        tick();
        clear_redirect();
        #1;
        checks++; if (dec.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b want 0", dec.out_valid); end
        checks++; if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'h100) begin
            errors++; $display("FAIL flush_req: got v=%b addr=%h want v=1 addr=100", imem.req_valid, imem.req_addr); end
        dec.out_ready = 1'b1;
        wait_out(ok);
        checks++; if (!ok || dec.out_pc !== 30'h40 || dec.out_instr !== 32'h100) begin
            errors++; $display("FAIL flush_out: got ok=%b pc=%h instr=%h want ok=1 pc=40 instr=100", ok, dec.out_pc, dec.out_instr); end
    endtask

    task automatic test_jump_priority();
        mem_lat = 1;
        dec.out_ready = 1'b1;
        do_reset();
        j = 1'b1; j_imm = 24'hABCDEF; jr = 1'b1; jr_target = 30'h200; br_eq = 1'b1; zero = 1'b1;
        #1;
        checks++; if (imem.req_valid !== 1'b0) begin errors++; $display("FAIL jp_suppress: got req_valid=%b want 0", imem.req_valid); end
        tick();
        clear_redirect();
        j = 1'b1; j_imm = 24'h123456; br_pc = 30'h2A001234;
        #1;
        checks++; if (imem.req_addr !== 32'h800) begin errors++; $display("FAIL jp_jr_target: got %h want 800", imem.req_addr); end
        checks++; if (imem.req_valid !== 1'b0) begin errors++; $display("FAIL jp_j_suppress: got req_valid=%b want 0", imem.req_valid); end
        tick();
        clear_redirect();
        br_eq = 1'b1; zero = 1'b0;
        #1;
        checks++; if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'hA848D158) begin
            errors++; $display("FAIL jp_j_target: got v=%b addr=%h want v=1 addr=a848d158", imem.req_valid, imem.req_addr); end
        tick();
        clear_redirect();
        checks++; if (acc_log.size() != 1 || acc_log[0] !== 32'hA848D158) begin
            errors++; $display("FAIL jp_accept_log: got size=%0d want one accept at a848d158", acc_log.size()); end
    endtask

    task automatic test_wrap();
        bit ok;
        mem_lat = 1;
        dec.out_ready = 1'b1;
        do_reset();
        jr = 1'b1; jr_target = 30'h3FFFFFFF;
        tick();
        clear_redirect();
        #1;
        checks++; if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'hFFFFFFFC) begin
            errors++; $display("FAIL wrap_top_req: got v=%b addr=%h want v=1 addr=fffffffc", imem.req_valid, imem.req_addr); end
        wait_out(ok);
        checks++; if (!ok || dec.out_pc !== 30'h3FFFFFFF || dec.out_instr !== 32'hFFFFFFFC) begin
            errors++; $display("FAIL wrap_top_out: got ok=%b pc=%h instr=%h want ok=1 pc=3fffffff instr=fffffffc", ok, dec.out_pc, dec.out_instr); end
        checks++; if ($isunknown(imem.req_addr) || imem.req_addr !== 32'h0) begin
            errors++; $display("FAIL wrap_next_addr: got %h want 0", imem.req_addr); end
        wait_out(ok);
        checks++; if (!ok || dec.out_pc !== 30'h0 || dec.out_instr !== 32'h0) begin
            errors++; $display("FAIL wrap_zero_out: got ok=%b pc=%h instr=%h want ok=1 pc=0 instr=0", ok, dec.out_pc, dec.out_instr); end
    endtask

    task automatic test_mid_reset();
        bit ok;
        mem_lat = 3;
        dec.out_ready = 1'b1;
        do_reset();
        tick();
        rst = 1'b0;
        imem.req_ready = 1'b0;
        #1;
        checks++; if (imem.req_valid !== 1'b0 || imem.req_addr !== 32'h0 || dec.out_valid !== 1'b0) begin
            errors++; $display("FAIL mrst_in_reset: got v=%b addr=%h out=%b want 0 0 0", imem.req_valid, imem.req_addr, dec.out_valid); end
        tick();
        rst = 1'b1;
        #1;
        checks++; if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'h0) begin
            errors++; $display("FAIL mrst_restart: got v=%b addr=%h want v=1 addr=0", imem.req_valid, imem.req_addr); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (dec.out_valid !== 1'b0) begin errors++; $display("FAIL mrst_orphan_%0d: got out_valid=%b want 0", i, dec.out_valid); end
        end
        imem.req_ready = 1'b1;
        wait_out(ok);
        checks++; if (!ok || dec.out_pc !== 30'h0 || dec.out_instr !== 32'h0) begin
            errors++; $display("FAIL mrst_first_out: got ok=%b pc=%h instr=%h want ok=1 pc=0 instr=0", ok, dec.out_pc, dec.out_instr); end
    endtask

    initial begin
        rst = 1'b0;
        imem.req_ready = 1'b1;
        imem.rsp_valid = 1'b0;
        imem.rsp_instr = '0;
        dec.out_ready  = 1'b1;
        clear_redirect();
        test_reset();
        test_stream();
        test_backpressure();
        test_branch();
        test_flush();
        test_jump_priority();
        test_wrap();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised, handshaked instruction-fetch stage replacing the single-cycle fetch path. It holds the word-addressed PC and issues one request at a time to a variable-latency instruction memory. Returned instructions are buffered in a small in-order queue for decode. Branch, jump and jump-register redirects are resolved here; stale in-flight responses are discarded.

## Interface
Parameters:
- PC_W, 30, word-address width of PC; byte address = {pc, 2'b00}
- INSTR_W, 32, instruction width
- DEPTH, 2, fetch-queue entries (power of two, ≥2)
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req_valid  out  1  imem request valid
- req_ready  in  1  imem accepts request
- req_addr  out  PC_W+2  byte address, low 2 bits zero
- rsp_valid  in  1  imem response valid (never before the accepting cycle +1)
- rsp_instr  in  INSTR_W  response data
- out_valid  out  1  queue head valid
- out_ready  in  1  decode consumes head
- out_instr  out  INSTR_W  head instruction
- out_pc  out  PC_W  head instruction word address
- br_eq, br_ne, zero  in  1 each  conditional branch controls
- br_pc  in  PC_W  word address of the branch
- br_imm  in  16  signed word offset
- j  in  1  direct jump
- j_imm  in  24  jump target low bits
- jr  in  1  register jump
- jr_target  in  PC_W  register target

## Operation
- Taken branch: take = (br_eq & zero) | (br_ne & ~zero).
- Branch target = br_pc + 1 + sext(br_imm), computed modulo 2^PC_W.
- j target = {br_pc[upper PC_W-24 bits], j_imm}.
- jr target = jr_target.
- Redirect priority: jr > j > take. The redirect is valid when any of these is true.
- FSM states:
  - IDLE: no outstanding request.
  - WAIT: one request accepted, response pending.
  - DROP: pending response belongs to a flushed path.
- IDLE: req_valid = 1 when (queue count + 0) < DEPTH and no redirect this cycle. On req_valid & req_ready: go to WAIT and advance fetch_pc by 1.
- WAIT: on rsp_valid, push {pc, rsp_instr} into the queue and go to IDLE.
- Redirect in any state:
  - Flush the queue (count = 0) and set fetch_pc = target.
  - WAIT goes to DROP. A rsp_valid arriving in the same cycle is discarded.
  - IDLE stays IDLE. An in-cycle handshake is suppressed because req_valid is forced to 0.
- DROP: on rsp_valid, discard the response and go to IDLE. A redirect in DROP updates fetch_pc only.
- Queue is FIFO. On a simultaneous push and pop, count is unchanged.
- A push never occurs when full, because requests are only issued with a free slot.
- PC increments wrap modulo 2^PC_W.
- Reset values:
  - fetch_pc = RESET_PC, state IDLE, queue empty.
  - req_valid = 0 during reset, req_addr = {RESET_PC,00}.
  - out_valid = 0, out_instr = 0, out_pc = 0.

## Timing
- All state is registered. req_addr and out_* are driven from registers and the queue head.
- Request issue to earliest queue head: accept at cycle t, rsp_valid at t+k (k ≥ 1), out_valid at t+k+1.
- Redirect at cycle t: req_addr = target and req_valid = 1 from t+1 (from IDLE). From DROP, the first request follows the stale response.
- out_valid/out_ready: the head is held stable while out_valid & ~out_ready.
- Redirect in cycle t clears out_valid from t+1.
- Deasserting rst mid-transaction abandons the outstanding request. The memory must tolerate an orphan response, which is ignored in IDLE.

## Structure
- Shared package fetch_pkg: FSM state encoding (IDLE/WAIT/DROP) and the default PC_W/INSTR_W.
- Sub-module next_pc_sel (combinational): takes the branch/jump inputs and produces redirect, target.
- Queue is inline in fetch_unit: head/tail pointers plus a count of width clog2(DEPTH)+1.

## Test plan
- Reset, out_ready=1, 1-cycle imem returning addr as data → req_addr 0,4,8,…; out_pc 0,1,2 with out_instr 0,4,8.
- out_ready=0 with DEPTH=2 → exactly 2 requests issued, then req_valid=0. Release → queue drains with pc 0,1, then fetch resumes at pc 2.
- Branch at br_pc=0x10, br_imm=0xFFFE, br_ne=1, zero=0 while WAIT with 3-cycle imem → stale response dropped, queue flushed, next req_addr=0x3C (pc 0xF).
- j=1, jr=1, jr_target=0x200 in same cycle → target 0x200; j_imm ignored.
- fetch_pc=2^30-1 → next req_addr 0, no X.
- Assert rst low during WAIT, release → req_addr=RESET_PC<<2 and out_valid=0; the late orphan rsp_valid is not pushed.
